ibex_rf_wb_buffer: RTL and testbench

//  Write-back buffer between the WB stage and the cached register file's write port.

---
 rtl/ibex_rf_wb_pkg.sv | 12 +
 rtl/ibex_rf_wb_fwd_match.sv | 33 +++
 rtl/ibex_rf_wb_buffer.sv | 106 ++++++++++
 tb/tb_ibex_rf_wb_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ibex_rf_wb_pkg.sv
// Shared types for the register-file write-back buffer.
package ibex_rf_wb_pkg;

    localparam int unsigned RegAddrW  = 5;
    localparam int unsigned DataWidth = 32;

    typedef struct packed {
        logic [RegAddrW-1:0]  waddr;
        logic [DataWidth-1:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/ibex_rf_wb_fwd_match.sv
// Age-ordered match of a read address against the buffered writes; youngest match wins.
module ibex_rf_wb_fwd_match
    import ibex_rf_wb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  wb_entry_t                  entries_i [Depth],
    input  logic [Depth-1:0]           valids_i,
    input  logic [$clog2(Depth)-1:0]   rd_ptr_i,
    input  logic [RegAddrW-1:0]        raddr_i,
    output logic                       hit_o,
    output logic [DataWidth-1:0]       data_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0] idx;

    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            idx = rd_ptr_i + PtrW'(i);
            if (valids_i[idx] && (entries_i[idx].waddr == raddr_i) && (raddr_i != '0)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].wdata;
            end
        end
    end

endmodule

// File: rtl/ibex_rf_wb_buffer.sv
// In-order write-back buffer in front of the cached register file write port,
// with forwarding of pending writes to the two read ports.
module ibex_rf_wb_buffer
    import ibex_rf_wb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_we_i,
    input  logic [RegAddrW-1:0]   wb_waddr_i,
    input  logic [DataWidth-1:0]  wb_wdata_i,
    output logic                  wb_ready_o,
    output logic                  rf_we_o,
    output logic [RegAddrW-1:0]   rf_waddr_o,
    output logic [DataWidth-1:0]  rf_wdata_o,
    input  logic                  rf_stall_i,
    input  logic [RegAddrW-1:0]   raddr_a_i,
    output logic                  fwd_a_hit_o,
    output logic [DataWidth-1:0]  fwd_a_data_o,
    input  logic [RegAddrW-1:0]   raddr_b_i,
    output logic                  fwd_b_hit_o,
    output logic [DataWidth-1:0]  fwd_b_data_o,
    output logic                  empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    wb_entry_t        entries_q [Depth];
    logic [Depth-1:0] valid_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [CntW-1:0]  count_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Full comes from the count alone, so a same-cycle pop never frees a slot for WB.
    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);
    assign push  = wb_we_i && !full && (wb_waddr_i != '0);
    assign pop   = !empty && !rf_stall_i;

    assign wb_ready_o = !full;
    assign empty_o    = empty;
    assign rf_we_o    = !empty;
    assign rf_waddr_o = empty ? '0 : entries_q[rd_ptr_q].waddr;
    assign rf_wdata_o = empty ? '0 : entries_q[rd_ptr_q].wdata;

    always_ff @(posedge clk_i) begin
        if (push) begin
            entries_q[wr_ptr_q] <= '{waddr: wb_waddr_i, wdata: wb_wdata_i};
        end
    end

    // Pointers, count and valids; pending writes are dropped on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (pop) begin
                rd_ptr_q          <= rd_ptr_q + PtrW'(1);
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (push) begin
                wr_ptr_q          <= wr_ptr_q + PtrW'(1);
                valid_q[wr_ptr_q] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    ibex_rf_wb_fwd_match #(.Depth(Depth)) u_fwd_a (
        .entries_i (entries_q),
        .valids_i  (valid_q),
        .rd_ptr_i  (rd_ptr_q),
        .raddr_i   (raddr_a_i),
        .hit_o     (fwd_a_hit_o),
        .data_o    (fwd_a_data_o)
    );

    ibex_rf_wb_fwd_match #(.Depth(Depth)) u_fwd_b (
        .entries_i (entries_q),
        .valids_i  (valid_q),
        .rd_ptr_i  (rd_ptr_q),
        .raddr_i   (raddr_b_i),
        .hit_o     (fwd_b_hit_o),
        .data_o    (fwd_b_data_o)
    );

    // Accepted writes only when ready; head held steady while the register file stalls.
    a_push_ready: assert property (@(posedge clk_i) disable iff (rst_i) push |-> wb_ready_o);
    a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (rf_we_o && rf_stall_i) |=> (rf_we_o && $stable(rf_waddr_o) && $stable(rf_wdata_o)));

endmodule

// File: tb/tb_ibex_rf_wb_buffer.sv
// Directed table-driven bench for ibex_rf_wb_buffer plus pointer-wrap and age-order sequences.
module tb_ibex_rf_wb_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        wb_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_stall_i;
    logic [4:0]  raddr_a_i;
    logic        fwd_a_hit_o;
    logic [31:0] fwd_a_data_o;
    logic [4:0]  raddr_b_i;
    logic        fwd_b_hit_o;
    logic [31:0] fwd_b_data_o;
    logic        empty_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    ibex_rf_wb_buffer #(.Depth(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wb_we_i      (wb_we_i),
        .wb_waddr_i   (wb_waddr_i),
        .wb_wdata_i   (wb_wdata_i),
        .wb_ready_o   (wb_ready_o),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .rf_stall_i   (rf_stall_i),
        .raddr_a_i    (raddr_a_i),
        .fwd_a_hit_o  (fwd_a_hit_o),
        .fwd_a_data_o (fwd_a_data_o),
        .raddr_b_i    (raddr_b_i),
        .fwd_b_hit_o  (fwd_b_hit_o),
        .fwd_b_data_o (fwd_b_data_o),
        .empty_o      (empty_o)
    );

    // Inputs applied for one cycle and the outputs expected before that cycle's edge.
    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_ha;
        logic [31:0] e_da;
        logic        e_hb;
        logic [31:0] e_db;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [31:0] rst, we, wa, wd, st, ra, rb,
        input logic [31:0] ry, rfwe, ewa, ewd, ha, da, hb, db);
        vec_t v;
        v.rst = rst[0];      v.we = we[0];        v.wa = 5'(wa);    v.wd = wd;
        v.st = st[0];        v.ra = 5'(ra);       v.rb = 5'(rb);
        v.e_ready = ry[0];   v.e_we = rfwe[0];    v.e_wa = 5'(ewa); v.e_wd = ewd;
        v.e_ha = ha[0];      v.e_da = da;         v.e_hb = hb[0];   v.e_db = db;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst_i      = v.rst;
        wb_we_i    = v.we;
        wb_waddr_i = v.wa;
        wb_wdata_i = v.wd;
        rf_stall_i = v.st;
        raddr_a_i  = v.ra;
        raddr_b_i  = v.rb;
        #1;
        chk($sformatf("v%0d ready", idx),    32'(wb_ready_o),  32'(v.e_ready));
        chk($sformatf("v%0d rf_we", idx),    32'(rf_we_o),     32'(v.e_we));
        chk($sformatf("v%0d empty", idx),    32'(empty_o),     32'(!v.e_we));
        chk($sformatf("v%0d rf_waddr", idx), 32'(rf_waddr_o),  32'(v.e_wa));
        chk($sformatf("v%0d rf_wdata", idx), rf_wdata_o,       v.e_wd);
        chk($sformatf("v%0d hit_a", idx),    32'(fwd_a_hit_o), 32'(v.e_ha));
        chk($sformatf("v%0d hit_b", idx),    32'(fwd_b_hit_o), 32'(v.e_hb));
        if (v.e_ha) chk($sformatf("v%0d data_a", idx), fwd_a_data_o, v.e_da);
        if (v.e_hb) chk($sformatf("v%0d data_b", idx), fwd_b_data_o, v.e_db);
        tick();
    endtask

    initial begin
        //                 rst we wa  wd            st ra  rb   ry we wa  wd           ha da           hb db
        // Reset state
        vecs.push_back(mk(0, 0, 0,  0,            0, 5,  7,   1, 0, 0,  0,           0, 0,           0, 0));
        // Single write, no stall: visible one cycle later, forwards while popping
        vecs.push_back(mk(0, 1, 5,  'hDEAD_BEEF,  0, 5,  0,   1, 0, 0,  0,           0, 0,           0, 0));
        vecs.push_back(mk(0, 0, 0,  0,            0, 5,  0,   1, 1, 5,  'hDEAD_BEEF, 1, 'hDEAD_BEEF, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,            0, 5,  0,   1, 0, 0,  0,           0, 0,           0, 0));
        // Fill under stall, push while full ignored, then in-order drain
        vecs.push_back(mk(0, 1, 1,  'h11,         1, 1,  2,   1, 0, 0,  0,           0, 0,           0, 0));
        vecs.push_back(mk(0, 1, 2,  'h22,         1, 1,  2,   1, 1, 1,  'h11,        1, 'h11,        0, 0));
        vecs.push_back(mk(0, 1, 3,  'h33,         1, 1,  2,   1, 1, 1,  'h11,        1, 'h11,        1, 'h22));
        vecs.push_back(mk(0, 1, 4,  'h44,         1, 3,  4,   1, 1, 1,  'h11,        1, 'h33,        0, 0));
        vecs.push_back(mk(0, 1, 6,  'h66,         1, 6,  4,   0, 1, 1,  'h11,        0, 0,           1, 'h44));
        vecs.push_back(mk(0, 0, 0,  0,            1, 6,  4,   0, 1, 1,  'h11,        0, 0,           1, 'h44));
        vecs.push_back(mk(0, 0, 0,  0,            0, 6,  1,   0, 1, 1,  'h11,        0, 0,           1, 'h11));
        vecs.push_back(mk(0, 0, 0,  0,            0, 1,  2,   1, 1, 2,  'h22,        0, 0,           1, 'h22));
        vecs.push_back(mk(0, 0, 0,  0,            0, 0,  3,   1, 1, 3,  'h33,        0, 0,           1, 'h33));
        vecs.push_back(mk(0, 0, 0,  0,            0, 4,  6,   1, 1, 4,  'h44,        1, 'h44,        0, 0));
        vecs.push_back(mk(0, 0, 0,  0,            0, 4,  6,   1, 0, 0,  0,           0, 0,           0, 0));
        // Same register written twice: youngest forwards, both drain
        vecs.push_back(mk(0, 1, 7,  'hA,          1, 7,  0,   1, 0, 0,  0,           0, 0,           0, 0));
        vecs.push_back(mk(0, 1, 7,  'hB,          1, 7,  0,   1, 1, 7,  'hA,         1, 'hA,         0, 0));
        vecs.push_back(mk(0, 0, 0,  0,            1, 7,  0,   1, 1, 7,  'hA,         1, 'hB,         0, 0));
        vecs.push_back(mk(0, 0, 0,  0,            0, 7,  0,   1, 1, 7,  'hA,         1, 'hB,         0, 0));
        vecs.push_back(mk(0, 0, 0,  0,            0, 7,  0,   1, 1, 7,  'hB,         1, 'hB,         0, 0));
        vecs.push_back(mk(0, 0, 0,  0,            0, 7,  0,   1, 0, 0,  0,           0, 0,           0, 0));
        // Write to x0 dropped
        vecs.push_back(mk(0, 1, 0,  'hFFFF,       0, 0,  0,   1, 0, 0,  0,           0, 0,           0, 0));
        vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,   1, 0, 0,  0,           0, 0,           0, 0));
        // Full with push+pop in the same cycle: push ignored, count 4 -> 3
        vecs.push_back(mk(0, 1, 8,  'h81,         1, 8,  9,   1, 0, 0,  0,           0, 0,           0, 0));
        vecs.push_back(mk(0, 1, 9,  'h91,         1, 8,  9,   1, 1, 8,  'h81,        1, 'h81,        0, 0));
        vecs.push_back(mk(0, 1, 10, 'hA1,         1, 8,  9,   1, 1, 8,  'h81,        1, 'h81,        1, 'h91));
        vecs.push_back(mk(0, 1, 11, 'hB1,         1, 10, 11,  1, 1, 8,  'h81,        1, 'hA1,        0, 0));
        vecs.push_back(mk(0, 1, 12, 'hC1,         0, 12, 11,  0, 1, 8,  'h81,        0, 0,           1, 'hB1));
        vecs.push_back(mk(0, 0, 0,  0,            1, 12, 11,  1, 1, 9,  'h91,        0, 0,           1, 'hB1));
        // Reset with three pending writes discards them
        vecs.push_back(mk(1, 0, 0,  0,            1, 9,  11,  1, 1, 9,  'h91,        1, 'h91,        1, 'hB1));
        vecs.push_back(mk(0, 0, 0,  0,            1, 9,  11,  1, 0, 0,  0,           0, 0,           0, 0));

        rst_i = 1'b1; wb_we_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;
        rf_stall_i = 1'b0; raddr_a_i = '0; raddr_b_i = '0;
        tick();
        tick();
        chk("reset data_a", fwd_a_data_o, 32'h0);
        chk("reset data_b", fwd_b_data_o, 32'h0);

        foreach (vecs[i]) apply(vecs[i], i);

        // Ten back-to-back push/pop pairs across pointer wrap
        rst_i = 1'b0; rf_stall_i = 1'b0; raddr_a_i = '0; raddr_b_i = '0;
        for (int k = 0; k <= 10; k++) begin
            wb_we_i    = (k < 10);
            wb_waddr_i = 5'(k + 1);
            wb_wdata_i = 32'h1000_0000 + 32'(k) * 32'h111;
            #1;
            if (k > 0) begin
                chk($sformatf("wrap%0d rf_we", k),    32'(rf_we_o),    32'h1);
                chk($sformatf("wrap%0d rf_waddr", k), 32'(rf_waddr_o), 32'(k));
                chk($sformatf("wrap%0d rf_wdata", k), rf_wdata_o,      32'h1000_0000 + 32'(k - 1) * 32'h111);
                chk($sformatf("wrap%0d ready", k),    32'(wb_ready_o), 32'h1);
            end
            tick();
        end
        wb_we_i = 1'b0;
        #1;
        chk("wrap empty", 32'(empty_o), 32'h1);

        // Four writes to x3 with the youngest landing at a lower index than the head
        rf_stall_i = 1'b1; raddr_a_i = 5'd3;
        for (int k = 0; k < 4; k++) begin
            wb_we_i = 1'b1; wb_waddr_i = 5'd3; wb_wdata_i = 32'(k + 1);
            tick();
        end
        wb_we_i = 1'b0;
        #1;
        chk("age ready", 32'(wb_ready_o),  32'h0);
        chk("age hit_a", 32'(fwd_a_hit_o), 32'h1);
        chk("age data_a", fwd_a_data_o,    32'h4);
        rf_stall_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("age drain%0d waddr", k), 32'(rf_waddr_o), 32'h3);
            chk($sformatf("age drain%0d wdata", k), rf_wdata_o,      32'(k + 1));
            chk($sformatf("age drain%0d data_a", k), fwd_a_data_o,   32'h4);
            tick();
        end
        #1;
        chk("age final empty", 32'(empty_o),     32'h1);
        chk("age final hit_a", 32'(fwd_a_hit_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
